// File: rtl/rtc_read_seq.sv
// rtl/rtc_read_seq.sv - RTC multiplexed address/data bus read sequencer
module rtc_read_seq #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic [6:0] data_bin,
    output logic       bcd_err
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE
    } state_t;

    // Counter reload values: a state lasting T cycles is entered with T-1.
    localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
    localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);
    localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] addr_q, addr_n;
    logic       capture;

    logic [7:0] bus_out_nx;
    logic       bus_oe_nx, cs_nx, rd_nx, wr_nx, ad_nx, busy_nx, done_nx;

    // The byte on the pad is taken on the last cycle of the RD pulse.
    assign capture = (state == D_PULSE) && (cnt == 4'd0);

    // Next-state: walk the phases, reloading the down-counter on each entry.
    // DONE spends one strobes-high cycle before the done pulse cycle.
    always_comb begin
        state_n = state;
        cnt_n   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        addr_n  = addr_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = A_SETUP;
                    cnt_n   = LD_SETUP;
                    addr_n  = addr;
                end
            end
            A_SETUP: if (cnt == 4'd0) begin state_n = A_PULSE; cnt_n = LD_PULSE; end
            A_PULSE: if (cnt == 4'd0) begin state_n = A_HOLD;  cnt_n = LD_HOLD;  end
            A_HOLD:  if (cnt == 4'd0) begin state_n = GAP;     cnt_n = LD_GAP;   end
            GAP:     if (cnt == 4'd0) begin state_n = D_SETUP; cnt_n = LD_SETUP; end
            D_SETUP: if (cnt == 4'd0) begin state_n = D_PULSE; cnt_n = LD_PULSE; end
            D_PULSE: if (cnt == 4'd0) begin state_n = D_HOLD;  cnt_n = LD_HOLD;  end
            D_HOLD:  if (cnt == 4'd0) begin state_n = DONE;    cnt_n = 4'd1;     end
            DONE:    if (cnt == 4'd0) begin state_n = IDLE;    cnt_n = 4'd0;     end
            default: begin state_n = IDLE; cnt_n = 4'd0; end
        endcase
    end

    // Output decode from the next state, so the pins come straight off flops.
    always_comb begin
        bus_out_nx = 8'h00;
        bus_oe_nx  = 1'b0;
        cs_nx      = 1'b1;
        rd_nx      = 1'b1;
        wr_nx      = 1'b1;
        ad_nx      = 1'b1;
        busy_nx    = 1'b1;
        done_nx    = 1'b0;
        case (state_n)
            IDLE: busy_nx = 1'b0;
            A_SETUP, A_HOLD: begin
                cs_nx = 1'b0; ad_nx = 1'b0; bus_oe_nx = 1'b1; bus_out_nx = addr_n;
            end
            A_PULSE: begin
                cs_nx = 1'b0; ad_nx = 1'b0; bus_oe_nx = 1'b1; bus_out_nx = addr_n;
                wr_nx = 1'b0;
            end
            D_SETUP, D_HOLD: cs_nx = 1'b0;
            D_PULSE: begin cs_nx = 1'b0; rd_nx = 1'b0; end
            DONE:    done_nx = (cnt_n == 4'd0);
            default: ;
        endcase
    end

    // State, counter, latched address and registered pin outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 8'h00;
            bus_out <= 8'h00;
            bus_oe  <= 1'b0;
            CS      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            AD      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            bus_out <= bus_out_nx;
            bus_oe  <= bus_oe_nx;
            CS      <= cs_nx;
            RD      <= rd_nx;
            WR      <= wr_nx;
            AD      <= ad_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    // Read data register, held until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_out <= 8'h00;
        else if (capture)
            data_out <= data_in;
    end

    // Bit 7 is the clock-halt/format flag and is not part of the BCD value.
    assign data_bin = 7'(data_out[6:4]) * 7'd10 + 7'(data_out[3:0]);
    assign bcd_err  = (data_out[3:0] > 4'd9) | ({1'b0, data_out[6:4]} > 4'd9);

endmodule

// File: tb/tb_rtc_read_seq.sv
// tb/tb_rtc_read_seq.sv - self-checking bench for rtc_read_seq
module tb_rtc_read_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [7:0] addr_s, data_s;

    logic [7:0] bus0, bus1, dout0, dout1;
    logic       oe0, cs0, rd0, wr0, ad0, busy0, done0, err0;
    logic       oe1, cs1, rd1, wr1, ad1, busy1, done1, err1;
    logic [6:0] bin0, bin1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rtc_read_seq dut0 (
        .clk(clk), .reset(reset), .start(start0), .addr(addr_s), .data_in(data_s),
        .bus_out(bus0), .bus_oe(oe0), .CS(cs0), .RD(rd0), .WR(wr0), .AD(ad0),
        .busy(busy0), .done(done0), .data_out(dout0), .data_bin(bin0), .bcd_err(err0)
    );

    rtc_read_seq #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .addr(addr_s), .data_in(data_s),
        .bus_out(bus1), .bus_oe(oe1), .CS(cs1), .RD(rd1), .WR(wr1), .AD(ad1),
        .busy(busy1), .done(done1), .data_out(dout1), .data_bin(bin1), .bcd_err(err1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_out;
        logic [6:0] exp_bin;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed as {CS, RD, WR, AD, bus_oe, busy, done}.
    function automatic logic [6:0] strobes(input int sel);
        return (sel != 0) ? {cs1, rd1, wr1, ad1, oe1, busy1, done1}
                          : {cs0, rd0, wr0, ad0, oe0, busy0, done0};
    endfunction

    function automatic logic [7:0] bus(input int sel);
        return (sel != 0) ? bus1 : bus0;
    endfunction

    function automatic logic [7:0] dout(input int sel);
        return (sel != 0) ? dout1 : dout0;
    endfunction

    function automatic logic [6:0] dbin(input int sel);
        return (sel != 0) ? bin1 : bin0;
    endfunction

    function automatic logic derr(input int sel);
        return (sel != 0) ? err1 : err0;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start1 = v;
        else          start0 = v;
    endtask

    // The RD/bus_oe overlap must never happen on either instance.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((oe0 && !rd0) || (oe1 && !rd1)) begin
                failures++;
                $display("FAIL oe_rd_overlap oe0=%b rd0=%b oe1=%b rd1=%b", oe0, rd0, oe1, rd1);
            end
        end
    end

    // One read, checked cycle by cycle against the phase timeline derived
    // from the timing parameters. Cycle i is the one after edge k+i.
    task automatic run_read(input int sel, input logic [7:0] a, input logic [7:0] d,
                            input bit poke, input bit done_poke);
        int s, p, h, g, ph, tot, j;
        logic [6:0] exp;
        logic [6:0] bin_e;
        logic       err_e;
        s = (sel != 0) ? 1 : 2;
        p = (sel != 0) ? 1 : 4;
        h = (sel != 0) ? 1 : 2;
        g = (sel != 0) ? 1 : 2;
        ph  = s + p + h;
        tot = 2 * ph + g;
        bin_e = 7'(((d >> 4) & 8'h07) * 10 + (d & 8'h0f));
        err_e = ((d & 8'h0f) > 9);
        addr_s = a;
        data_s = d;
        set_start(sel, 1'b1);
        @(negedge clk);
        for (int i = 0; i <= tot + 3; i++) begin
            if (i < ph)
                exp = {1'b0, 1'b1, !(i >= s && i < s + p), 1'b0, 1'b1, 1'b1, 1'b0};
            else if (i < ph + g)
                exp = 7'b1111010;
            else if (i < tot) begin
                j = i - ph - g;
                exp = {1'b0, !(j >= s && j < s + p), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            end else if (i == tot)
                exp = 7'b1111010;
            else if (i == tot + 1)
                exp = 7'b1111011;
            else
                exp = 7'b1111000;
            chk($sformatf("strobes[%0d]", i), strobes(sel), exp);
            if (i < ph)
                chk("bus_out", bus(sel), a);
            if (i == tot + 1 || i == tot + 3) begin
                chk("data_out", dout(sel), d);
                chk("bcd_err", derr(sel), err_e);
                if (!err_e)
                    chk("data_bin", dbin(sel), bin_e);
            end
            addr_s = ~a;
            if (i >= tot + 1)
                data_s = 8'($urandom);
            set_start(sel, (poke && (i == 3 || i == 10)) || (done_poke && i == tot + 1));
            @(negedge clk);
        end
        set_start(sel, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'h02, 8'h59, 8'h59, 7'd59, 1'b0};
        tbl[1] = '{8'h10, 8'hA3, 8'hA3, 7'd23, 1'b0};
        tbl[2] = '{8'h05, 8'h3C, 8'h3C, 7'd0,  1'b1};
        tbl[3] = '{8'h7F, 8'h00, 8'h00, 7'd0,  1'b0};
        tbl[4] = '{8'hFF, 8'h79, 8'h79, 7'd79, 1'b0};
        tbl[5] = '{8'h33, 8'h80, 8'h80, 7'd0,  1'b0};

        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        addr_s = 8'h00;
        data_s = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_strobes0", strobes(0), 7'b1111000);
        chk("reset_bus0", bus0, 8'h00);
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            chk("idle_strobes0", strobes(0), 7'b1111000);
            chk("idle_strobes1", strobes(1), 7'b1111000);
            chk("idle_dout0", dout0, 8'h00);
            @(negedge clk);
        end

        for (int v = 0; v < 6; v++) begin
            run_read(0, tbl[v].a, tbl[v].d, 1'b0, 1'b0);
            chk("tbl_data_out", dout0, tbl[v].exp_out);
            chk("tbl_bcd_err", err0, tbl[v].exp_err);
            if (!tbl[v].exp_err)
                chk("tbl_data_bin", bin0, tbl[v].exp_bin);
        end

        run_read(0, 8'h0A, 8'h42, 1'b1, 1'b1);
        run_read(0, 8'h0B, 8'h17, 1'b1, 1'b0);

        addr_s = 8'h44;
        data_s = 8'h12;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (13) @(negedge clk);
        chk("rd_low_before_reset", rd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_mid_strobes", strobes(0), 7'b1111000);
        chk("reset_mid_bus", bus0, 8'h00);
        chk("reset_mid_dout", dout0, 8'h00);
        chk("reset_mid_bin", bin0, 7'd0);
        chk("reset_mid_err", err0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            chk("no_resume", strobes(0), 7'b1111000);
            @(negedge clk);
        end
        run_read(0, 8'h21, 8'h47, 1'b0, 0);

        for (int n = 0; n < 100; n++)
            run_read(1, 8'($urandom), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        for (int n = 0; n < 5; n++)
            run_read(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_read_seq.md
# rtc_read_seq

Bus read sequencer for the RTC's multiplexed address/data parallel interface: the read-side counterpart of the per-field write timing generators. On a start pulse it performs one register read: address phase (AD low, WR strobe, address driven on the shared bus), then data phase (AD high, RD strobe, bus released and sampled). It returns the raw byte plus a BCD-to-binary conversion, and sits beside the write generators under the RTC controller, which arbitrates bus ownership.

## Interface
- T_SETUP, 2: cycles CS/AD/bus are stable before each strobe (1..15)
- T_PULSE, 4: cycles WR or RD is held low (1..15)
- T_HOLD, 2: cycles CS/AD/bus are held after each strobe (1..15)
- T_GAP, 2: cycles with CS high between address and data phases (1..15)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- addr  in  8  RTC register address; latched when start is accepted
- data_in  in  8  bus value from the RTC pad (tri-state input side)
- bus_out  out  8  address byte driven onto the bus
- bus_oe  out  1  1 = bus_out drives the pad
- CS, RD, WR, AD  out  1 each  active-low RTC strobes
- busy  out  1  1 from acceptance until DONE completes
- done  out  1  one-cycle pulse; data valid
- data_out  out  8  captured raw byte
- data_bin  out  7  binary value of data_out[6:0] as BCD
- bcd_err  out  1  either nibble of data_out[6:0] > 9

## Operation
- FSM states: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE. Each timed state lasts exactly its parameter in cycles, counted by a 4-bit down-counter reloaded on entry.
- IDLE: CS=RD=WR=AD=1, bus_oe=0, busy=0. If start=1, latch addr and go to A_SETUP.
- A_SETUP: CS=0, AD=0, bus_oe=1, bus_out=latched addr, WR=1.
- A_PULSE: as A_SETUP with WR=0.
- A_HOLD: WR=1; CS, AD, bus_oe unchanged.
- GAP: CS=1, AD=1, bus_oe=0.
- D_SETUP: CS=0, AD=1, RD=1, bus_oe=0.
- D_PULSE: RD=0. data_in is captured into data_out on the final cycle of D_PULSE, at the edge leaving it.
- D_HOLD: RD=1, CS=0.
- DONE: one cycle with done=1, all strobes high, then IDLE.
- bus_oe and RD=0 are never asserted in the same cycle. bus_oe drops at the A_HOLD→GAP edge, at least T_GAP+T_SETUP cycles before RD falls.
- data_bin = data_out[6:4]*10 + data_out[3:0]. Bit 7 (the clock-halt/format flag) is excluded. This logic is combinational from data_out.
- bcd_err = (data_out[3:0] > 9) | (data_out[6:4] > 9). data_bin is undefined while bcd_err=1.
- data_out, data_bin and bcd_err hold their values until the next capture.

## Timing
- All outputs are registered and change only on clk edges, so the RTC sees glitch-free strobes.
- When start is sampled at edge k in IDLE:
  - A_SETUP outputs appear after edge k.
  - done is high for exactly the one cycle following edge k + 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1.
  - With default parameters, done follows edge k+19.
- start while busy=1 is ignored and not queued. start in the DONE cycle is ignored. start in IDLE right after DONE is accepted, so back-to-back reads are spaced by one idle cycle.
- A change on addr after acceptance has no effect on the transaction in progress.
- Reset (asynchronous, at any point, including mid-strobe): the FSM goes to IDLE immediately. CS=RD=WR=AD=1, bus_oe=0, bus_out=0, busy=0, done=0, data_out=0, so data_bin=0 and bcd_err=0. The aborted read is not resumed.

## Test plan
- Reset then idle: all strobes 1, bus_oe=0, data_out=0, busy=0 for 20 cycles with start=0.
- Read addr=0x02 with the RTC model returning 0x59 (defaults): AD/CS low with bus_out=0x02 for 8 cycles, WR low for 4 of them. Then 2 gap cycles, then RD low for 4 cycles. done pulses once, 19 cycles after start, with data_out=0x59, data_bin=59, bcd_err=0.
- Data 0xA3 with bit7 set (0x80|0x23): data_bin=23, bcd_err=0. Data 0x3C: bcd_err=1.
- start pulses during busy (at cycles 3 and 10): ignored, exactly one done, and the address is the first one latched.
- Assert reset during D_PULSE: outputs go to idle values within the same cycle (before the next edge), no done, data_out=0. A new start then completes normally.
- T_SETUP=1, T_PULSE=1, T_HOLD=1, T_GAP=1: latency is 8 cycles, and bus_oe is never high while RD=0 (assertion over 100 random reads).
